// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared definitions for the two-source mux arbiter.
//   state_t  - FSM state encoding (IDLE / GNT0 / GNT1)
//   SEL_D0/1 - mux select values passing d0 / d1
//   CNT_W    - width of the per-grant beat counter
//   sat_inc  - saturating increment for the beat counter
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic SEL_D0 = 1'b0;
  localparam logic SEL_D1 = 1'b1;

  localparam int CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// mux: single-bit 2:1 multiplexer cell of the shared datapath.
// Ports:
//   s  - select (0 passes d0, 1 passes d1)
//   d0 - input 0
//   d1 - input 1
//   y  - selected output (combinational)
module mux (
  input  logic s,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter that owns the select of the
// shared 2:1 mux, sequences bursts from both sources through it, and presents
// the registered mux output downstream with a valid strobe.
//
// Optional feature macro: MUX_ARB_TIMEOUT_EN
//   defined   - a burst is cut after MAX_BURST beats when the other source
//               is waiting; otherwise the beat counter saturates.
//   undefined - no beat counter is built; bursts are unbounded.
//
// Parameters:
//   WIDTH     - data width in bits
//   MAX_BURST - beat limit per grant (1..255), timeout build only
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   req0, req1   - per-source request, held for the whole burst
//   last0, last1 - per-source final-beat marker
//   d0, d1       - per-source data
//   gnt0, gnt1   - grant, decoded from the state register
//   sel          - mux select driven into the mux cells
//   y, y_valid   - registered mux output and its beat strobe
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             last0,
  input  logic             last1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             ptr_r;        // 0: favour source 0, 1: favour source 1
  logic             ptr_nxt_s;
  logic             sel_r;
  logic             sel_nxt_s;
  logic             beat_s;
  logic             limit_s;      // beat counter has reached the burst limit
  logic [WIDTH-1:0] mux_y_s;
  logic [WIDTH-1:0] y_r;
  logic             y_valid_r;

  if ((MAX_BURST < 1) || (MAX_BURST > 255)) begin : g_bad_max_burst
    $error("mux_arbiter: MAX_BURST must be in 1..255");
  end

  // Datapath: one mux cell per data bit, all steered by the registered select.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux u_mux (
      .s  (sel_r),
      .d0 (d0[i]),
      .d1 (d1[i]),
      .y  (mux_y_s[i])
    );
  end

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_r;
  logic             entry_s;

  // Counter reaching MAX_BURST on this beat means it already holds MAX_BURST-1.
  assign limit_s = (cnt_r >= CNT_W'(MAX_BURST - 1));
  assign entry_s = (state_nxt_s != state_r) && (state_nxt_s != IDLE);

  // Beat counter: cleared on every grant entry, saturating count of beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (entry_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (beat_s) begin
      cnt_r <= sat_inc(cnt_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign limit_s = 1'b0;
`endif

  // Next-state, pointer and beat decode. An end-of-burst hands over directly
  // when the other source is already requesting, so the stream has no bubble.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    beat_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt_s = ptr_r ? GNT1 : GNT0;
        end else if (req0) begin
          state_nxt_s = GNT0;
        end else if (req1) begin
          state_nxt_s = GNT1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT0: begin
        beat_s = req0;
        if (!req0 || last0 || (limit_s && req1)) begin
          ptr_nxt_s   = 1'b1;
          state_nxt_s = req1 ? GNT1 : IDLE;
        end else begin
          state_nxt_s = GNT0;
        end
      end
      GNT1: begin
        beat_s = req1;
        if (!req1 || last1 || (limit_s && req0)) begin
          ptr_nxt_s   = 1'b0;
          state_nxt_s = req0 ? GNT0 : IDLE;
        end else begin
          state_nxt_s = GNT1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Select follows the grant being entered or held; it keeps its value in IDLE.
  always_comb begin
    sel_nxt_s = sel_r;
    case (state_nxt_s)
      GNT0:    sel_nxt_s = SEL_D0;
      GNT1:    sel_nxt_s = SEL_D1;
      default: sel_nxt_s = sel_r;
    endcase
  end

  // Control registers: FSM state, round-robin pointer, mux select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 1'b0;
      sel_r   <= SEL_D0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      sel_r   <= sel_nxt_s;
    end
  end

  // Output register: capture the mux on a beat, hold data otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r       <= {WIDTH{1'b0}};
      y_valid_r <= 1'b0;
    end else if (beat_s) begin
      y_r       <= mux_y_s;
      y_valid_r <= 1'b1;
    end else begin
      y_r       <= y_r;
      y_valid_r <= 1'b0;
    end
  end

  assign gnt0    = (state_r == GNT0);
  assign gnt1    = (state_r == GNT1);
  assign sel     = sel_r;
  assign y       = y_r;
  assign y_valid = y_valid_r;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: self-checking bench for mux_arbiter (WIDTH=4, MAX_BURST=4).
// Directed vector table, hand-written reset / burst-limit sequences, and a
// randomized run checked against a behavioural model of the arbitration rules.
module tb_mux_arbiter;

  localparam int W    = 4;
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1, last0, last1;
  logic [W-1:0] d0, d1;
  logic         gnt0, gnt1, sel, y_valid;
  logic [W-1:0] y;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .last0(last0), .last1(last1),
    .d0(d0), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .y(y), .y_valid(y_valid)
  );

  typedef struct {
    logic r0, r1, l0, l1;
    logic [W-1:0] a, b;
    logic [7:0] exp;   // {gnt0, gnt1, sel, y_valid, y}
  } vec_t;

  vec_t tbl[23];

  // Behavioural model state: owner -1 means nobody holds the mux.
  int         m_owner, m_fav, m_beats;
  logic       m_sel, m_yv;
  logic [W-1:0] m_y;

  function automatic vec_t mk(input int r0, r1, l0, l1, a, b, g0, g1, s, v, yy);
    vec_t t;
    t.r0 = 1'(r0); t.r1 = 1'(r1); t.l0 = 1'(l0); t.l1 = 1'(l1);
    t.a = W'(a); t.b = W'(b);
    t.exp = {1'(g0), 1'(g1), 1'(s), 1'(v), W'(yy)};
    return t;
  endfunction

  function automatic logic [7:0] obs();
    return {gnt0, gnt1, sel, y_valid, y};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {g0,g1,sel,v,y}=%b required %b", name, got, exp);
  endtask

  task automatic drive(input logic r0, r1, l0, l1, input logic [W-1:0] a, b);
    req0 = r0; req1 = r1; last0 = l0; last1 = l1; d0 = a; d1 = b;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_fav = 0; m_beats = 0; m_sel = 1'b0; m_yv = 1'b0; m_y = '0;
  endtask

  // Applies one cycle of the arbitration rules to the model.
  task automatic model_step();
    logic rq[2];
    logic ls[2];
    logic [W-1:0] dd[2];
    logic beat, fin;
    int oth;
    rq[0] = req0; rq[1] = req1; ls[0] = last0; ls[1] = last1; dd[0] = d0; dd[1] = d1;
    beat = 1'b0;
    if (m_owner >= 0) beat = rq[m_owner];
    m_yv = beat;
    if (beat) m_y = dd[m_owner];
    if (m_owner < 0) begin
      if (rq[0] && rq[1]) m_owner = m_fav;
      else if (rq[0]) m_owner = 0;
      else if (rq[1]) m_owner = 1;
      if (m_owner >= 0) begin m_sel = 1'(m_owner); m_beats = 0; end
    end else begin
      oth = 1 - m_owner;
      fin = !rq[m_owner] || ls[m_owner];
`ifdef MUX_ARB_TIMEOUT_EN
      if (beat && (m_beats + 1 >= MAXB) && rq[oth]) fin = 1'b1;
`endif
      if (fin) begin
        m_fav = oth;
        if (rq[oth]) begin m_owner = oth; m_sel = 1'(oth); m_beats = 0; end
        else m_owner = -1;
      end else begin
        m_beats++;
      end
    end
  endtask

  function automatic logic [7:0] model_obs();
    return {m_owner == 0, m_owner == 1, m_sel, m_yv, m_y};
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check("reset_state", obs(), 8'h00);

    //           r0 r1 l0 l1  a   b  | g0 g1 s  v  y
    tbl[0]  = mk(1, 0, 0, 0,  1,  0,   1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0,  1,  0,   1, 0, 0, 1, 1);
    tbl[2]  = mk(1, 0, 0, 0,  1,  0,   1, 0, 0, 1, 1);
    tbl[3]  = mk(1, 0, 1, 0,  1,  0,   0, 0, 0, 1, 1);
    tbl[4]  = mk(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 1);
    tbl[5]  = mk(1, 1, 0, 0,  3,  5,   0, 1, 1, 0, 1);
    tbl[6]  = mk(1, 1, 0, 0,  3,  6,   0, 1, 1, 1, 6);
    tbl[7]  = mk(1, 1, 0, 1,  3,  7,   1, 0, 0, 1, 7);
    tbl[8]  = mk(1, 1, 0, 0,  9,  0,   1, 0, 0, 1, 9);
    tbl[9]  = mk(1, 1, 1, 0, 10,  0,   0, 1, 1, 1, 10);
    tbl[10] = mk(0, 1, 0, 0,  0, 11,   0, 1, 1, 1, 11);
    tbl[11] = mk(1, 0, 0, 0, 12,  0,   1, 0, 0, 0, 11);
    tbl[12] = mk(1, 0, 1, 0, 13,  0,   0, 0, 0, 1, 13);
    tbl[13] = mk(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 13);
    tbl[14] = mk(0, 1, 0, 1,  0, 14,   0, 1, 1, 0, 13);
    tbl[15] = mk(0, 1, 0, 1,  0, 14,   0, 0, 1, 1, 14);
    tbl[16] = mk(0, 0, 0, 0,  0,  0,   0, 0, 1, 0, 14);
    tbl[17] = mk(1, 1, 0, 0,  0,  0,   1, 0, 0, 0, 14);
    tbl[18] = mk(1, 1, 0, 0,  2,  0,   1, 0, 0, 1, 2);
    tbl[19] = mk(1, 1, 1, 0,  3,  0,   0, 1, 1, 1, 3);
    tbl[20] = mk(0, 1, 0, 0,  0,  4,   0, 1, 1, 1, 4);
    tbl[21] = mk(0, 1, 0, 1,  0,  5,   0, 0, 1, 1, 5);
    tbl[22] = mk(0, 0, 0, 0,  0,  0,   0, 0, 1, 0, 5);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1, tbl[i].a, tbl[i].b);
      step();
      check($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // Asynchronous reset in the middle of a source-1 burst (sel is 1 here).
    drive(0, 1, 0, 0, 0, 7);
    step();
    check("rst_burst_grant", obs(), {4'b0110, 4'd5});
    step();
    check("rst_burst_beat", obs(), {4'b0111, 4'd7});
    #2 rst_n = 1'b0;
    #1 check("rst_async_clear", obs(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("rst_idle_after", obs(), 8'h00);
    drive(1, 1, 0, 0, 0, 0);
    step();
    check("rst_ptr_favours0", obs(), 8'h80);

    // Burst limit with the other source waiting.
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    step();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 0, 0, W'(i), 0);
      step();
`ifdef MUX_ARB_TIMEOUT_EN
      if (i < 4) check($sformatf("limit_beat%0d", i), obs(), {4'b1001, W'(i)});
      else       check("limit_handover", obs(), {4'b0111, W'(i)});
`else
      check($sformatf("unbounded_beat%0d", i), obs(), {4'b1001, W'(i)});
`endif
    end

    // No waiting source: the burst runs past the limit.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 0, 0, W'(i), 0);
      step();
      check($sformatf("long_beat%0d", i), obs(), {4'b1001, W'(i)});
    end
    drive(1, 1, 0, 0, 4'd11, 0);
    step();
`ifdef MUX_ARB_TIMEOUT_EN
    check("long_then_cut", obs(), {4'b0111, 4'd11});
`else
    check("long_no_cut", obs(), {4'b1001, 4'd11});
`endif

    // Randomized run against the behavioural model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
            W'($urandom), W'($urandom));
      model_step();
      step();
      check($sformatf("rand%0d", c), obs(), model_obs());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
